// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: font table, blank pattern, decode kinds,
// segment bit positions and output-register states.
package seg7_pkg;

    localparam int SEG_W = 7;

    // Segment bit positions on the active-high bus.
    typedef enum int unsigned {
        SEG_A = 0,
        SEG_B = 1,
        SEG_C = 2,
        SEG_D = 3,
        SEG_E = 4,
        SEG_F = 5,
        SEG_G = 6
    } seg7_seg_e;

    // Active-high g..a patterns, index = hex value (entry 15 listed first).
    localparam logic [15:0][SEG_W-1:0] SEG7_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [SEG_W-1:0] SEG7_BLANK = 7'h00;

    typedef enum logic [1:0] {
        KIND_DIGIT   = 2'd0,
        KIND_BLANK   = 2'd1,
        KIND_INVALID = 2'd2
    } seg7_kind_e;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } seg7_out_state_e;

    // Bring a raw bus to active-high form.
    function automatic logic [SEG_W-1:0] seg7_normalise(input logic [SEG_W-1:0] seg,
                                                        input logic active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seg7_font_inv.sv
// Inverse font lookup: active-high segment pattern -> {kind, hex digit}.
module seg7_font_inv
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] i_pattern,
    output seg7_kind_e       o_kind,
    output logic [3:0]       o_digit
);

    // Default to INVALID/0, then override on blank or any font match.
    always_comb begin
        o_kind  = KIND_INVALID;
        o_digit = 4'd0;
        if (i_pattern == SEG7_BLANK) begin
            o_kind = KIND_BLANK;
        end
        for (int i = 0; i < 16; i++) begin
            if (i_pattern == SEG7_HEX[i]) begin
                o_kind  = KIND_DIGIT;
                o_digit = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// Seven-segment capture: samples the segment bus, waits for a stable pattern,
// decodes it and offers each new stable pattern as a valid/ready event.
//
// state     | meaning
// ----------+----------------------------------------------
// OUT_EMPTY | no event held, out_valid low
// OUT_FULL  | event held in output register, out_valid high
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEG_W-1:0] seg_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_digit,
    output logic [1:0]       out_kind,
    output logic [SEG_W-1:0] out_raw,
    output logic             overflow
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0] w_seg_n;
    logic [SEG_W-1:0] r_seg_q;
    logic [SEG_W-1:0] r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [SEG_W-1:0] r_last_acc;
    logic             w_accept;
    logic             w_event;
    seg7_kind_e       w_kind;
    logic [3:0]       w_digit;
    seg7_out_state_e  r_state;
    seg7_out_state_e  w_state_nxt;
    logic             w_load;
    logic             w_drop;
    logic [3:0]       r_digit;
    seg7_kind_e       r_kind;
    logic [SEG_W-1:0] r_raw;
    logic             r_overflow;

    assign w_seg_n = seg7_normalise(seg_i, ACTIVE_LOW);

    // The accept strobe fires on the one cycle where the count is about to
    // reach its saturation value, so each stable run accepts exactly once.
    assign w_accept = (r_seg_q == r_cand) && (r_cnt == CNT_ACC);
    assign w_event  = w_accept && (r_cand != r_last_acc);

    seg7_font_inv u_font_inv (
        .i_pattern (r_cand),
        .o_kind    (w_kind),
        .o_digit   (w_digit)
    );

    // Input sampling and stability tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_q <= '0;
            r_cand  <= '0;
            r_cnt   <= '0;
        end else begin
            r_seg_q <= w_seg_n;
            if (r_seg_q != r_cand) begin
                r_cand <= r_seg_q;
                r_cnt  <= CNT_W'(1);
            end else if (r_cnt < CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Last accepted pattern; updated on every new event, including dropped ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_acc <= SEG7_BLANK;
        end else if (w_event) begin
            r_last_acc <= r_cand;
        end
    end

    // Output FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OUT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OUT_EMPTY: if (w_event) w_state_nxt = OUT_FULL;
            OUT_FULL:  if (out_ready && !w_event) w_state_nxt = OUT_EMPTY;
            default:   w_state_nxt = OUT_EMPTY;
        endcase
    end

    // Output FSM outputs: valid flag plus load/drop decisions for this cycle.
    always_comb begin
        out_valid = (r_state == OUT_FULL);
        w_load    = w_event && ((r_state == OUT_EMPTY) || out_ready);
        w_drop    = w_event && (r_state == OUT_FULL) && !out_ready;
    end

    // Event payload; held unchanged until a new event is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit <= 4'd0;
            r_kind  <= KIND_DIGIT;
            r_raw   <= '0;
        end else if (w_load) begin
            r_digit <= w_digit;
            r_kind  <= w_kind;
            r_raw   <= r_cand;
        end
    end

    // Sticky drop indicator, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign out_digit = r_digit;
    assign out_kind  = r_kind;
    assign out_raw   = r_raw;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: one active-low instance (default parameters) and one
// active-high instance, each with an expected-event queue and a monitor.
module tb_seg7_capture;

    typedef struct packed {
        logic [3:0] digit;
        logic [1:0] kind;
        logic [6:0] raw;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_a, seg_b;
    logic       ra, rb;
    logic       a_valid, b_valid;
    logic [3:0] a_digit, b_digit;
    logic [1:0] a_kind, b_kind;
    logic [6:0] a_raw, b_raw;
    logic       a_ovf, b_ovf;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seg7_capture #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .seg_i     (seg_a),
        .out_valid (a_valid),
        .out_ready (ra),
        .out_digit (a_digit),
        .out_kind  (a_kind),
        .out_raw   (a_raw),
        .overflow  (a_ovf)
    );

    seg7_capture #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b0)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .seg_i     (seg_b),
        .out_valid (b_valid),
        .out_ready (rb),
        .out_digit (b_digit),
        .out_kind  (b_kind),
        .out_raw   (b_raw),
        .overflow  (b_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic [6:0] pat, input int n);
        seg_a = ~pat;
        repeat (n) tick();
    endtask

    task automatic drive_b(input logic [6:0] pat, input int n);
        seg_b = pat;
        repeat (n) tick();
    endtask

    function automatic void push_a(input logic [3:0] d, input logic [1:0] k, input logic [6:0] r);
        q_a.push_back(exp_t'{digit: d, kind: k, raw: r});
    endfunction

    function automatic void push_b(input logic [3:0] d, input logic [1:0] k, input logic [6:0] r);
        q_b.push_back(exp_t'{digit: d, kind: k, raw: r});
    endfunction

    // Monitor A: every transfer must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && a_valid && ra) begin
            n_vec++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL a_event: got unexpected raw %0h digit %0h kind %0d, required none",
                         a_raw, a_digit, a_kind);
            end else begin
                e_a = q_a.pop_front();
                if ({a_digit, a_kind, a_raw} !== e_a) begin
                    n_fail++;
                    $display("FAIL a_event: got digit %0h kind %0d raw %0h, required digit %0h kind %0d raw %0h",
                             a_digit, a_kind, a_raw, e_a.digit, e_a.kind, e_a.raw);
                end
            end
        end
    end

    // Monitor B: same scheme for the active-high instance.
    always @(negedge clk) begin
        if (!rst && b_valid && rb) begin
            n_vec++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL b_event: got unexpected raw %0h digit %0h kind %0d, required none",
                         b_raw, b_digit, b_kind);
            end else begin
                e_b = q_b.pop_front();
                if ({b_digit, b_kind, b_raw} !== e_b) begin
                    n_fail++;
                    $display("FAIL b_event: got digit %0h kind %0d raw %0h, required digit %0h kind %0d raw %0h",
                             b_digit, b_kind, b_raw, e_b.digit, e_b.kind, e_b.raw);
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        seg_a = 7'h7F;
        seg_b = 7'h00;
        ra    = 1'b1;
        rb    = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("rst_valid", a_valid, 0);
        check("rst_digit", a_digit, 0);
        check("rst_kind",  a_kind,  0);
        check("rst_raw",   a_raw,   0);
        check("rst_ovf",   a_ovf,   0);
        check("rst_b_valid", b_valid, 0);

        // Blank bus after reset: nothing emitted by either instance.
        drive_a(7'h00, 8);
        check("blank_no_event", a_valid, 0);

        // Active-high instance: invalid pattern, then blank.
        push_b(4'd0, 2'd2, 7'h52);
        drive_b(7'h52, 8);
        push_b(4'd0, 2'd1, 7'h00);
        drive_b(7'h00, 8);

        // Latency: digit 3 applied before edge 1, valid after edge 5.
        push_a(4'd3, 2'd0, 7'h4F);
        seg_a = ~7'h4F;
        repeat (4) tick();
        check("lat_edge4_valid", a_valid, 0);
        tick();
        check("lat_edge5_valid", a_valid, 1);
        check("lat_edge5_raw",   a_raw,   7'h4F);
        repeat (5) tick();

        // Short glitch is ignored; a full-length glitch gives two events.
        push_a(4'd1, 2'd0, 7'h06);
        drive_a(7'h06, 8);
        drive_a(7'h7F, 2);
        drive_a(7'h06, 8);
        push_a(4'd8, 2'd0, 7'h7F);
        drive_a(7'h7F, 4);
        push_a(4'd1, 2'd0, 7'h06);
        drive_a(7'h06, 8);

        // Back-pressure: 2 held, 5 dropped, overflow set.
        ra = 1'b0;
        push_a(4'd2, 2'd0, 7'h5B);
        drive_a(7'h5B, 8);
        drive_a(7'h6D, 8);
        check("ovf_hold_valid", a_valid, 1);
        check("ovf_hold_digit", a_digit, 2);
        check("ovf_hold_raw",   a_raw,   7'h5B);
        check("ovf_flag",       a_ovf,   1);
        ra = 1'b1;
        tick();
        tick();
        check("ovf_release_empty", a_valid, 0);
        check("ovf_queue_drained", q_a.size(), 0);
        check("ovf_sticky", a_ovf, 1);

        // Full with ready on the accept edge: old leaves, new loads same edge.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst2_ovf_clear", a_ovf, 0);
        ra = 1'b0;
        push_a(4'd9, 2'd0, 7'h6F);
        drive_a(7'h6F, 8);
        check("xfer_full_before", a_valid, 1);
        push_a(4'd10, 2'd0, 7'h77);
        seg_a = ~7'h77;
        repeat (4) tick();
        ra = 1'b1;
        tick();
        check("xfer_valid_stays", a_valid, 1);
        check("xfer_new_raw",     a_raw,   7'h77);
        check("xfer_new_digit",   a_digit, 10);
        check("xfer_no_ovf",      a_ovf,   0);
        repeat (3) tick();
        check("xfer_empty_after", a_valid, 0);

        // Reset while counting (cnt=2): restart, event after 5 more edges.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seg_a = ~7'h4F;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rstcnt_valid", a_valid, 0);
        check("rstcnt_raw",   a_raw,   0);
        rst = 1'b0;
        push_a(4'd3, 2'd0, 7'h4F);
        repeat (4) tick();
        check("rstcnt_edge4_valid", a_valid, 0);
        tick();
        check("rstcnt_edge5_valid", a_valid, 1);
        repeat (4) tick();

        // Reset while FULL: held event lost, then re-emitted after release.
        ra = 1'b0;
        seg_a = ~7'h39;
        repeat (6) tick();
        check("rstfull_before_valid", a_valid, 1);
        check("rstfull_before_digit", a_digit, 12);
        rst = 1'b1;
        tick();
        check("rstfull_valid", a_valid, 0);
        check("rstfull_digit", a_digit, 0);
        check("rstfull_kind",  a_kind,  0);
        check("rstfull_raw",   a_raw,   0);
        check("rstfull_ovf",   a_ovf,   0);
        rst = 1'b0;
        ra  = 1'b1;
        push_a(4'd12, 2'd0, 7'h39);
        repeat (4) tick();
        check("rstfull_edge4_valid", a_valid, 0);
        tick();
        check("rstfull_edge5_valid", a_valid, 1);
        repeat (4) tick();

        check("end_queue_a", q_a.size(), 0);
        check("end_queue_b", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
